// File: rtl/reg_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_arbiter
// Description : Round-robin arbiter that shares one register-file read port
//               (the 32:1 read mux) between up to four requesters. It drives
//               the mux select and captures the read data into a one-entry
//               response register with valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [5*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]     req_ready,
    output logic [4:0]          mux_sel,
    input  logic [WIDTH-1:0]    mux_dout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_id,
    output logic [WIDTH-1:0]    rsp_data
);

    // Response-register occupancy: the state is exactly the rsp_valid bit.
    localparam logic       c_st_empty = 1'b0;
    localparam logic       c_st_full  = 1'b1;
    // Pointer reset value gives requester 0 first priority.
    localparam logic [1:0] c_last_rst = 2'(NREQ - 1);

    logic [3:0]       w_valid;
    logic [4:0]       w_addr [4];
    logic [2:0]       w_cand;
    logic             w_found;
    logic [1:0]       w_winner;
    logic [4:0]       w_win_addr;
    logic             w_can_issue;
    logic             w_grant;
    logic             w_state_nxt;

    logic             r_state;
    logic [1:0]       r_last;
    logic [1:0]       r_id;
    logic [WIDTH-1:0] r_data;

    // Normalise the request vectors to four slots; absent requesters never request.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < NREQ) begin : g_used
                assign w_valid[gi] = req_valid[gi];
                assign w_addr[gi]  = req_addr[5*gi +: 5];
            end else begin : g_unused
                assign w_valid[gi] = 1'b0;
                assign w_addr[gi]  = 5'd0;
            end
        end
    endgenerate

    // Round-robin search starting just after the last winner, wrapping modulo NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'd0;
        w_cand   = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            // r_last < NREQ and k <= NREQ, so one subtraction completes the wrap.
            w_cand = 3'(r_last) + 3'(k);
            if (w_cand >= 3'(NREQ)) begin
                w_cand = w_cand - 3'(NREQ);
            end
            if (!w_found && w_valid[w_cand[1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[1:0];
            end
        end
    end

    // A new read may only issue when the response slot is empty or draining now.
    assign w_can_issue = (r_state == c_st_empty) || rsp_ready;
    assign w_grant     = w_found && w_can_issue && !rst;
    assign w_win_addr  = w_addr[w_winner];
    assign mux_sel     = w_grant ? w_win_addr : 5'd0;

    // One-hot grant back to the winning requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = w_grant && (w_winner == 2'(gi));
        end
    endgenerate

    // Next-state logic for the response slot (EMPTY/FULL).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_grant) w_state_nxt = c_st_full;
            c_st_full:  if (rsp_ready && !w_grant) w_state_nxt = c_st_empty;
            default:    w_state_nxt = c_st_empty;
        endcase
    end

    // State, pointer and response capture; x0 reads are forced to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_empty;
            r_last  <= c_last_rst;
            r_id    <= 2'd0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last <= w_winner;
                r_id   <= w_winner;
                r_data <= (w_win_addr == 5'd0) ? '0 : mux_dout;
            end
        end
    end

    assign rsp_valid = (r_state == c_st_full);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;

endmodule
`default_nettype wire
